// File: rtl/md_sched_pkg.sv
// -----------------------------------------------------------------------------
// md_sched_pkg
// Shared definitions for the mul/div issue scheduler:
//   - md_state_e : scheduler FSM state encoding
//   - LANE_W     : width of the issue-lane identifier
//   - MD_MUL/DIV : encoding of the muldiv payload bit
// -----------------------------------------------------------------------------
package md_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } md_state_e;

    localparam int   LANE_W = 1;

    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

endpackage

// File: rtl/md_rr_arb.sv
// -----------------------------------------------------------------------------
// md_rr_arb
// Two-request round-robin arbiter with one-hot grant.
// Ports:
//   clk       : clock
//   rst_n     : asynchronous active-low reset (pointer returns to lane 0)
//   i_req     : request vector, bit N = lane N
//   i_advance : a grant was taken this cycle; move the pointer past it
//   o_grant   : one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module md_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    // Lane that wins when both lanes request.
    logic r_rr;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_rr ? 2'b10 : 2'b01;
        end
    end

    // After a grant the pointer favours the lane that was not served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= 1'b0;
        end else if (i_advance) begin
            r_rr <= ~o_grant[1];
        end
    end

endmodule

// File: rtl/md_sched.sv
// -----------------------------------------------------------------------------
// md_sched
// Arbitrates two issue lanes onto one shared mul/div unit, tracks the single
// in-flight operation and returns its result through a writeback port.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   reqN_valid/ready (N=0,1)      : issue-lane handshake
//   reqN_pc/op1/op2/dst/op/muldiv : issue-lane payload
//   md_valid/md_ready, md_*       : request to the mul/div unit (latched)
//   md_abort                      : flush forwarded while waiting on the unit
//   md_resp_valid/md_resp_result  : unit result
//   flush                         : kill the operation currently owned
//   busy, busy_dst                : hazard information for the owned op
//   wb_valid/wb_ready, wb_*       : writeback port
// -----------------------------------------------------------------------------
module md_sched
    import md_sched_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_pc,
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,
    input  logic [4:0]      req0_dst,
    input  logic [2:0]      req0_op,
    input  logic            req0_muldiv,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_pc,
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,
    input  logic [4:0]      req1_dst,
    input  logic [2:0]      req1_op,
    input  logic            req1_muldiv,
    output logic            md_valid,
    input  logic            md_ready,
    output logic [XLEN-1:0] md_pc,
    output logic [XLEN-1:0] md_op1,
    output logic [XLEN-1:0] md_op2,
    output logic [4:0]      md_dst,
    output logic [2:0]      md_op,
    output logic            md_muldiv,
    output logic            md_abort,
    input  logic            md_resp_valid,
    input  logic [XLEN-1:0] md_resp_result,
    input  logic            flush,
    output logic            busy,
    output logic [4:0]      busy_dst,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_dst,
    output logic [XLEN-1:0] wb_pc,
    output logic [XLEN-1:0] wb_result,
    output logic            wb_lane
);

    md_state_e         r_state;
    logic              r_killed;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [4:0]        r_dst;
    logic [2:0]        r_op;
    logic              r_muldiv;
    logic [LANE_W-1:0] r_lane;
    logic [XLEN-1:0]   r_result;

    logic              w_can_grant;
    logic [1:0]        w_req;
    logic [1:0]        w_grant;

    // rst_n is included so ready stays low while reset is held even if a lane
    // is presenting a request.
    assign w_can_grant = rst_n && (r_state == ST_IDLE) && !flush;
    assign w_req       = {req1_valid, req0_valid} & {2{w_can_grant}};

    md_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_req),
        .i_advance (|w_grant),
        .o_grant   (w_grant)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_killed <= 1'b0;
            r_pc     <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_dst    <= '0;
            r_op     <= '0;
            r_muldiv <= 1'b0;
            r_lane   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        if (w_grant[1]) begin
                            r_pc     <= req1_pc;
                            r_op1    <= req1_op1;
                            r_op2    <= req1_op2;
                            r_dst    <= req1_dst;
                            r_op     <= req1_op;
                            r_muldiv <= req1_muldiv;
                        end else begin
                            r_pc     <= req0_pc;
                            r_op1    <= req0_op1;
                            r_op2    <= req0_op2;
                            r_dst    <= req0_dst;
                            r_op     <= req0_op;
                            r_muldiv <= req0_muldiv;
                        end
                        r_lane  <= w_grant[1];
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Not yet accepted by the unit: a flush simply withdraws it.
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (md_ready) begin
                        r_killed <= 1'b0;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The unit owes us a response even after a flush, so a
                    // killed op stays here until that response is swallowed.
                    if (md_resp_valid) begin
                        if (r_killed || flush) begin
                            r_killed <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_result <= md_resp_result;
                            r_state  <= ST_HOLD;
                        end
                    end else if (flush) begin
                        r_killed <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Flush wins over a coincident wb_ready.
                    if (flush || wb_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign md_valid  = (r_state == ST_ISSUE);
    assign md_pc     = r_pc;
    assign md_op1    = r_op1;
    assign md_op2    = r_op2;
    assign md_dst    = r_dst;
    assign md_op     = r_op;
    assign md_muldiv = r_muldiv;
    assign md_abort  = flush && (r_state == ST_WAIT);

    assign busy      = (r_state != ST_IDLE);
    assign busy_dst  = r_dst;

    assign wb_valid  = (r_state == ST_HOLD);
    assign wb_dst    = r_dst;
    assign wb_pc     = r_pc;
    assign wb_result = r_result;
    assign wb_lane   = r_lane;

endmodule
